// File: rtl/sha256_msg_sched_if.sv
// rtl/sha256_msg_sched_if.sv - message-block input and schedule-word output handshakes
interface sha256_msg_sched_if;
  logic         msg_valid;
  logic         msg_ready;
  logic [255:0] msg_block;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;

  // upstream buffer and compression core side
  modport master (
    output msg_valid, msg_block, w_ready,
    input  msg_ready, w_valid, w_data, w_idx, w_last
  );

  // schedule stage side
  modport slave (
    input  msg_valid, msg_block, w_ready,
    output msg_ready, w_valid, w_data, w_idx, w_last
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule for a fixed 256-bit message
module sha256_msg_sched (
  input logic             clk,
  input logic             rst,
  sha256_msg_sched_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic        take_blk;
  logic        take_word;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Word that enters the top of the window; computed on every shift, even past round 47
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  assign bus.w_data = win[0];
  assign bus.w_idx  = t;
  assign bus.w_last = (state == RUN) && (t == 6'd63);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; outputs depend on state only
  always_comb begin
    state_nxt     = state;
    bus.msg_ready = 1'b0;
    bus.w_valid   = 1'b0;
    take_blk      = 1'b0;
    take_word     = 1'b0;
    case (state)
      IDLE: begin
        bus.msg_ready = 1'b1;
        if (bus.msg_valid) begin
          take_blk  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.w_valid = 1'b1;
        if (bus.w_ready) begin
          take_word = 1'b1;
          if (t == 6'd63) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window load with padding, then shift one word per transfer; t wraps 63 -> 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= 32'h0;
      t <= 6'd0;
    end else if (take_blk) begin
      for (int i = 0; i < 8; i++) win[i] <= bus.msg_block[255-32*i -: 32];
      win[8] <= 32'h8000_0000;
      for (int i = 9; i < 15; i++) win[i] <= 32'h0;
      win[15] <= 32'h0000_0100;
      t <= 6'd0;
    end else if (take_word) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
      t <= t + 6'd1;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - directed self-checking bench for sha256_msg_sched
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] ref_w [64];
  logic [31:0] cap   [64];

  sha256_msg_sched_if bus();

  sha256_msg_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_ref(input logic [255:0] blk);
    for (int i = 0; i < 8; i++) ref_w[i] = blk[255-32*i -: 32];
    ref_w[8] = 32'h8000_0000;
    for (int i = 9; i < 15; i++) ref_w[i] = 32'h0;
    ref_w[15] = 32'h0000_0100;
    for (int i = 16; i < 64; i++)
      ref_w[i] = ss1(ref_w[i-2]) + ref_w[i-7] + ss0(ref_w[i-15]) + ref_w[i-16];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one block at a negedge in IDLE and follow it for n_xfer transfers.
  task automatic run_block(input logic [255:0] blk, input int low_pct, input int n_xfer,
                           input bit hold, input logic [255:0] nxt);
    int t;
    int cyc;
    bit rdy;
    build_ref(blk);
    chk("accept_ready", 32'(bus.msg_ready), 32'd1);
    bus.msg_valid = 1'b1;
    bus.msg_block = blk;
    @(negedge clk);
    if (hold) bus.msg_block = nxt;
    else      bus.msg_valid = 1'b0;
    t   = 0;
    cyc = 0;
    while (t < n_xfer && cyc < 2000) begin
      chk($sformatf("w_valid[%0d]", t),   32'(bus.w_valid),   32'd1);
      chk($sformatf("msg_ready[%0d]", t), 32'(bus.msg_ready), 32'd0);
      chk($sformatf("w_idx[%0d]", t),     32'(bus.w_idx),     32'(t));
      chk($sformatf("w_data[%0d]", t),    bus.w_data,         ref_w[t]);
      chk($sformatf("w_last[%0d]", t),    32'(bus.w_last),    32'(t == 63));
      cap[t] = bus.w_data;
      rdy = (low_pct == 0) ? 1'b1 : ($urandom_range(99) >= low_pct);
      bus.w_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) t++;
    end
    chk("xfer_count", 32'(t), 32'(n_xfer));
    if (n_xfer == 64) begin
      chk("done_w_valid",   32'(bus.w_valid),   32'd0);
      chk("done_msg_ready", 32'(bus.msg_ready), 32'd1);
      if (low_pct == 0) chk("consecutive_cycles", 32'(cyc), 32'd64);
    end
  endtask

  initial begin
    logic [255:0] blk_a;
    logic [255:0] blk_b;

    rst           = 1'b1;
    bus.msg_valid = 1'b0;
    bus.msg_block = '0;
    bus.w_ready   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_msg_ready", 32'(bus.msg_ready), 32'd1);
    chk("rst_w_valid",   32'(bus.w_valid),   32'd0);
    chk("rst_w_last",    32'(bus.w_last),    32'd0);
    chk("rst_w_idx",     32'(bus.w_idx),     32'd0);
    chk("rst_w_data",    bus.w_data,         32'd0);

    // Idle hold with w_ready toggling
    for (int i = 0; i < 100; i++) begin
      bus.w_ready = 1'($urandom_range(1));
      @(negedge clk);
      chk("idle_w_valid",   32'(bus.w_valid),   32'd0);
      chk("idle_msg_ready", 32'(bus.msg_ready), 32'd1);
    end

    // Zero message, full throughput, hand-computed early words
    run_block('0, 0, 64, 1'b0, '0);
    chk("zero_w8",  cap[8],  32'h8000_0000);
    chk("zero_w15", cap[15], 32'h0000_0100);
    chk("zero_w16", cap[16], 32'h0000_0000);
    chk("zero_w17", cap[17], 32'h00A0_0000);
    chk("zero_w18", cap[18], 32'h0000_0000);
    chk("zero_w19", cap[19], 32'h0000_2844);

    // Modular wrap on W16
    blk_a = {32'hFFFF_FFFF, 32'h0000_0001, 192'h0};
    run_block(blk_a, 0, 64, 1'b0, '0);
    chk("wrap_w16", cap[16], 32'h0200_3FFF);

    // Random blocks under ~40% backpressure
    for (int k = 0; k < 3; k++) begin
      blk_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_block(blk_a, 40, 64, 1'b0, '0);
    end

    // Back-to-back: second block waits with msg_valid high during the first
    blk_a = {8{32'h0123_4567}};
    blk_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_block(blk_a, 0, 64, 1'b1, blk_b);
    run_block(blk_b, 0, 64, 1'b0, '0);

    // Reset after W20 transfers, then a fresh block
    blk_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_block(blk_a, 0, 21, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_w_valid",   32'(bus.w_valid),   32'd0);
    chk("abort_msg_ready", 32'(bus.msg_ready), 32'd1);
    chk("abort_w_idx",     32'(bus.w_idx),     32'd0);
    blk_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_block(blk_b, 0, 64, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
